// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default width for the serial adder
package serial_add_pkg;
  localparam int SERIAL_ADD_WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/result handshake bundle of the serial adder
// master: requester drives start_valid/a/b/cin(/sub)/result_ready
// slave: controller drives start_ready/result_valid/sum/cout/busy
// SERIAL_ADD_SUB_EN adds the sub request bit
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start_valid, a, b, cin, result_ready,
    input  start_ready, result_valid, sum, cout, busy
  );
  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start_valid, a, b, cin, result_ready,
    output start_ready, result_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl_adder.sv
// adder: 1-bit full-adder cell
// a_i, b_i, cin_i -> sum_o, cout_o
module adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer around one full-adder cell
// clk, rst_n (async active-low); bus = serial_add_ctrl_if.slave handshake bundle
// SERIAL_ADD_SUB_EN enables subtraction via bus.sub
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, start_ready_q, result_valid_q, busy_q;
  logic             cell_sum, cell_cout, sub_en;
`ifdef SERIAL_ADD_SUB_EN
  assign sub_en = bus.sub;
`else
  assign sub_en = 1'b0;
`endif
  adder u_adder (
    .a_i   (a_sr_q[0]),
    .b_i   (b_sr_q[0]),
    .cin_i (carry_q),
    .sum_o (cell_sum),
    .cout_o(cell_cout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      a_sr_q         <= '0;
      b_sr_q         <= '0;
      s_sr_q         <= '0;
      cnt_q          <= '0;
      carry_q        <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_valid) begin
          // subtraction is a + ~b + 1, so cout=1 means no borrow
          a_sr_q        <= bus.a;
          b_sr_q        <= sub_en ? ~bus.b : bus.b;
          carry_q       <= sub_en | bus.cin;
          cnt_q         <= '0;
          start_ready_q <= 1'b0;
          busy_q        <= 1'b1;
          state_q       <= RUN;
        end
        RUN: begin
          a_sr_q  <= a_sr_q >> 1;
          b_sr_q  <= b_sr_q >> 1;
          s_sr_q  <= {cell_sum, s_sr_q[WIDTH-1:1]};
          carry_q <= cell_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q        <= DONE;
            result_valid_q <= 1'b1;
          end
        end
        DONE: if (bus.result_ready) begin
          state_q        <= IDLE;
          result_valid_q <= 1'b0;
          start_ready_q  <= 1'b1;
          busy_q         <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.start_ready  = start_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sum          = s_sr_q;
  assign bus.cout         = carry_q;
  assign bus.busy         = busy_q;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial N-bit adder sequencer built around one shared 1-bit full-adder cell. It accepts operands through a valid/ready handshake and feeds the cell one bit per cycle, LSB first, with a registered carry. It returns the N-bit sum and carry-out through a second valid/ready handshake. It serves area-constrained datapaths that trade latency for a single adder cell.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operand request valid
start_ready  output  1  controller can accept operands
a  input  WIDTH  operand A, sampled only on start handshake
b  input  WIDTH  operand B, sampled only on start handshake
cin  input  1  carry-in, sampled only on start handshake
result_valid  output  1  sum/cout valid
result_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  final carry-out
busy  output  1  high in RUN or DONE

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous and active-low on rst_n. While rst_n=0: state=IDLE, and all shift registers, the carry and the counter are cleared. Output reset values: start_ready=1, result_valid=0, sum=0, cout=0, busy=0.
- States:
  - IDLE: start_ready=1. On start_valid&&start_ready, load A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, and move to RUN.
  - RUN: the cell inputs are A_sr[0], B_sr[0] and carry. Each cycle:
    - shift A_sr and B_sr right by 1;
    - shift the cell Sum into the MSB of S_sr (right shift);
    - carry<=cell Cout;
    - cnt<=cnt+1.
    When cnt==WIDTH-1, go to DONE on that edge.
  - DONE: result_valid=1, sum=S_sr, cout=carry, all held stable. On result_ready=1, return to IDLE on that edge. sum and cout keep their last values in IDLE.
- Latency: if the start handshake completes at edge E0, result_valid rises at edge E0+WIDTH. Throughput is one operation per WIDTH+2 cycles with result_ready tied high.
- start_ready=0 in RUN and DONE. start_valid is ignored there; there is no queuing. A new operation cannot be accepted in the same cycle as a result transfer.
- a, b and cin may change freely after the start handshake.
- sum is not meaningful while result_valid=0. The bench must compare only on the result handshake.
- Wrap-around: the result is modulo 2^WIDTH, and the overflow bit goes to cout only.
- Reset mid-RUN or mid-DONE: immediate return to the reset values; the in-flight result is discarded.
- busy = (state != IDLE).

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled on the start handshake. When sub=1, load B_sr<=~b and carry<=1, ignoring cin. The result is a-b modulo 2^WIDTH, and cout=1 means no borrow. When sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; add only.

Decomposition:
- Package serial_add_pkg holds:
  - state typedef enum {IDLE, RUN, DONE} (2-bit);
  - default-width constant SERIAL_ADD_WIDTH_DEF=8.
- One sub-module: the team's existing 1-bit full-adder cell adder (A, B, Cin -> Sum, Cout), instantiated once.
- The controller logic (FSM, shift registers, counter) stays in serial_add_ctrl itself.

Test Plan:
1. Reset: assert rst_n=0 mid-clock (asynchronous) -> outputs at reset values at once. After release, start_ready=1, busy=0.
2. Basic add, WIDTH=8: a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0. result_valid is high exactly 8 edges after accept.
3. Carry/wrap:
   - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
   - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
   - a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
4. Backpressure: hold result_ready=0 for 5 cycles after result_valid, and pulse start_valid with new operands during RUN and DONE -> sum/cout stable, start_ready=0, and the new request is not taken. Accept occurs only after returning to IDLE.
5. Reset mid-op: assert rst_n=0 at RUN cycle 4 of a=0xAA, b=0x55 -> immediately IDLE, result_valid=0, sum=0. The next op a=0x12, b=0x34 gives sum=0x46, cout=0.
6. With SERIAL_ADD_SUB_EN:
   - a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1.
   - a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
   - sub=0 repeats scenario 2's results.
